// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// State encodings, position count and the latched frame config.
package scan_seq_pkg;

  localparam int NUM_POS = 8;
  localparam int POS_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic [NUM_POS-1:0] mask;
    logic               cont;
  } frame_cfg_t;

endpackage

// File: rtl/scan_next_pos.sv
// Finds the next set mask bit above the current position,
// or the lowest set bit when first is high.
import scan_seq_pkg::*;

module scan_next_pos (
  input  logic [NUM_POS-1:0] mask,
  input  logic [POS_W-1:0]   cur,
  input  logic               first,
  output logic [POS_W-1:0]   nxt,
  output logic               last
);

  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt  = POS_W'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Scan sequencer driving the 3-to-8 decoder select and enable,
// with blanking gaps, per-position dwell and a skip mask.
import scan_seq_pkg::*;

module scan_seq #(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [7:0]         pos_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               frame_done
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam state_e ENTER_ST =
    (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

  state_e             state_q, state_d;
  frame_cfg_t         cfg_q, cfg_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [BW-1:0]      blank_cnt;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               load_blank, load_show;
  logic               done_d;

  logic [POS_W-1:0]   adv_pos, first_pos;
  logic               adv_last, first_none;

  logic [2:0]         sel_d;
  logic               en_d, busy_d;

  scan_next_pos u_adv (
    .mask  (cfg_q.mask),
    .cur   (pos_q),
    .first (1'b0),
    .nxt   (adv_pos),
    .last  (adv_last)
  );

  scan_next_pos u_first (
    .mask  (pos_mask),
    .cur   ('0),
    .first (1'b1),
    .nxt   (first_pos),
    .last  (first_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      dwell_q    <= '0;
      pos_q      <= '0;
      sel        <= '0;
      sel_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      dwell_q    <= dwell_d;
      pos_q      <= pos_d;
      sel        <= sel_d;
      sel_en     <= en_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Counters hold at zero rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      if (load_blank)
        blank_cnt <= BW'(BLANK_CYC - 1);
      else if (state_q == ST_BLANK && blank_cnt != '0)
        blank_cnt <= blank_cnt - BW'(1);

      if (load_show)
        dwell_cnt <= (dwell_d == '0) ? '0
                   : dwell_d - DWELL_W'(1);
      else if (state_q == ST_SHOW && dwell_cnt != '0)
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    dwell_d    = dwell_q;
    pos_d      = pos_q;
    done_d     = 1'b0;
    load_blank = 1'b0;
    load_show  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !first_none) begin
            cfg_d.mask = pos_mask;
            cfg_d.cont = cont;
            dwell_d    = dwell;
            pos_d      = first_pos;
            state_d    = ENTER_ST;
          end
        end
        ST_BLANK: begin
          if (blank_cnt == '0)
            state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (dwell_cnt == '0) begin
            if (!adv_last) begin
              pos_d   = adv_pos;
              state_d = ENTER_ST;
            end else begin
              done_d = 1'b1;
              if (cfg_q.cont && !first_none) begin
                cfg_d.mask = pos_mask;
                cfg_d.cont = cont;
                dwell_d    = dwell;
                pos_d      = first_pos;
                state_d    = ENTER_ST;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      load_blank = (state_d == ST_BLANK)
                && (state_q != ST_BLANK);
      load_show  = (state_d == ST_SHOW)
                && (state_q != ST_SHOW || dwell_cnt == '0);
    end
  end

  always_comb begin
    sel_d  = '0;
    en_d   = 1'b0;
    busy_d = 1'b0;
    if (state_d != ST_IDLE) begin
      sel_d  = pos_d;
      busy_d = 1'b1;
      en_d   = (state_d == ST_SHOW);
    end
  end

endmodule
